// File: rtl/game_pkg.sv
// Shared definitions for the cipher game levels: state encoding,
// default level-3 constants and the rotate-left helper.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    PASS,
    FAIL,
    LOCKED
  } state_t;

  localparam int LVL3_ROT   = 3;
  localparam int LVL3_TRIES = 3;

  // Widest operand the rotate helper handles; callers cast down to their width.
  localparam int ROTL_MAXW  = 64;
  localparam int ROTL_IDXW  = $clog2(ROTL_MAXW);

  // Rotates the low w bits of v left by r places. Bits at or above w are zero.
  // Callers must keep r below w.
  function automatic logic [ROTL_MAXW-1:0] rotl(input logic [ROTL_MAXW-1:0] v,
                                                input int w,
                                                input int r);
    logic [ROTL_MAXW-1:0] res;
    res = '0;
    for (int i = 0; i < ROTL_MAXW; i++) begin
      if (i < w) begin
        res[ROTL_IDXW'((i + r) % w)] = v[ROTL_IDXW'(i)];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, saturating stability
// counter and a single-cycle press pulse per stable press.
module btn_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          press_q;
  logic          press_d;

  // Bring the asynchronous button level into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Count stable-high cycles, saturating so a held button fires only once.
  always_comb begin
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (!sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(DB_CYCLES)) begin
      cnt_d   = cnt_q + CW'(1);
      press_d = (cnt_q == CW'(DB_CYCLES - 1));
    end
  end

  // Counter and pulse registers; the pulse coincides with the counter reaching its limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/level3_answer_checker.sv
// Level-3 answer checker: captures the switch answer on a debounced submit,
// compares it with rotl(plain ^ key, ROT), and tracks attempts and lockout.
module level3_answer_checker
  import game_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ROT       = LVL3_ROT,
  parameter int MAX_TRIES = LVL3_TRIES,
  parameter int DB_CYCLES = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [WIDTH-1:0]               plain_in,
  input  logic [WIDTH-1:0]               key_in,
  input  logic [WIDTH-1:0]               answer_in,
  input  logic                           submit_btn,
  input  logic                           new_round,
  output logic                           verifier,
  output logic [$clog2(MAX_TRIES+1)-1:0] attempts_left,
  output logic                           locked,
  output logic                           fail_pulse
);

  localparam int AW = $clog2(MAX_TRIES + 1);

  logic             press;
  logic [WIDTH-1:0] expected;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] ans_q;
  logic [WIDTH-1:0] ans_d;
  logic [AW-1:0]    att_q;
  logic [AW-1:0]    att_d;
  logic             verifier_q;
  logic             verifier_d;
  logic             locked_q;
  logic             locked_d;
  logic             fail_q;
  logic             fail_d;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (submit_btn),
    .press_o(press)
  );

  assign expected = WIDTH'(rotl(ROTL_MAXW'(plain_in ^ key_in), WIDTH, ROT));

  // Next-state logic; new_round overrides everything, including a same-cycle press.
  always_comb begin
    state_d = state_q;
    ans_d   = ans_q;
    att_d   = att_q;
    fail_d  = 1'b0;
    if (new_round) begin
      state_d = IDLE;
      att_d   = AW'(MAX_TRIES);
    end else begin
      case (state_q)
        IDLE, FAIL: begin
          if (press) begin
            ans_d   = answer_in;
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (ans_q == expected) begin
            state_d = PASS;
          end else begin
            fail_d = 1'b1;
            if (att_q != '0) begin
              att_d = att_q - AW'(1);
            end
            state_d = (att_q > AW'(1)) ? FAIL : LOCKED;
          end
        end
        PASS, LOCKED: begin
          state_d = state_q;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    verifier_d = (state_d == PASS);
    locked_d   = (state_d == LOCKED);
  end

  // State, captured answer, attempt counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ans_q      <= '0;
      att_q      <= AW'(MAX_TRIES);
      verifier_q <= 1'b0;
      locked_q   <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ans_q      <= ans_d;
      att_q      <= att_d;
      verifier_q <= verifier_d;
      locked_q   <= locked_d;
      fail_q     <= fail_d;
    end
  end

  assign verifier      = verifier_q;
  assign locked        = locked_q;
  assign fail_pulse    = fail_q;
  assign attempts_left = att_q;

endmodule

// File: tb/tb_level3_answer_checker.sv
// Self-checking bench for level3_answer_checker: directed scenarios followed
// by randomized submit/new-round traffic checked against a round-level model.
module tb_level3_answer_checker;

  localparam int W     = 8;
  localparam int ROTV  = 3;
  localparam int TRIES = 3;
  localparam int DB    = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] plainIn;
  logic [W-1:0] keyIn;
  logic [W-1:0] answerIn;
  logic         submitBtn;
  logic         newRound;
  logic         verifier;
  logic [1:0]   attemptsLeft;
  logic         locked;
  logic         failPulse;

  int checks;
  int errors;
  int failCount;

  int  mTries;
  bit  mPassed;
  bit  mLocked;
  int  mFails;

  level3_answer_checker #(
    .WIDTH    (W),
    .ROT      (ROTV),
    .MAX_TRIES(TRIES),
    .DB_CYCLES(DB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .plain_in     (plainIn),
    .key_in       (keyIn),
    .answer_in    (answerIn),
    .submit_btn   (submitBtn),
    .new_round    (newRound),
    .verifier     (verifier),
    .attempts_left(attemptsLeft),
    .locked       (locked),
    .fail_pulse   (failPulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tally every cycle in which the wrong-answer pulse is high.
  always @(negedge clk) begin
    if (failPulse === 1'b1) failCount++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Rotate-left of the XOR by slicing a doubled copy of the byte.
  function automatic logic [W-1:0] modelExp(input logic [W-1:0] p, input logic [W-1:0] k);
    logic [2*W-1:0] dbl;
    dbl = {p ^ k, p ^ k} << ROTV;
    return dbl[2*W-1:W];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".verifier"}, 32'(verifier), 32'(mPassed));
    checkOutput({tag, ".locked"}, 32'(locked), 32'(mLocked));
    checkOutput({tag, ".attempts"}, 32'(attemptsLeft), 32'(mTries));
    checkOutput({tag, ".failPulses"}, 32'(failCount), 32'(mFails));
  endtask

  task automatic modelRestart();
    mTries  = TRIES;
    mPassed = 1'b0;
    mLocked = 1'b0;
  endtask

  // Hold the button for a number of cycles, release, let things settle, and update the model.
  task automatic applyStimulus(input logic [W-1:0] ans, input int hold);
    @(negedge clk);
    answerIn  = ans;
    submitBtn = 1'b1;
    repeat (hold) @(negedge clk);
    submitBtn = 1'b0;
    repeat (12) @(negedge clk);
    if (hold >= DB && !mPassed && !mLocked) begin
      if (ans == modelExp(plainIn, keyIn)) begin
        mPassed = 1'b1;
      end else begin
        mTries--;
        mFails++;
        if (mTries == 0) mLocked = 1'b1;
      end
    end
  endtask

  task automatic pulseNewRound();
    @(negedge clk);
    newRound = 1'b1;
    @(negedge clk);
    newRound = 1'b0;
    repeat (3) @(negedge clk);
    modelRestart();
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    checkOutput("reset.verifier", 32'(verifier), 32'd0);
    checkOutput("reset.locked", 32'(locked), 32'd0);
    checkOutput("reset.attempts", 32'(attemptsLeft), 32'(TRIES));
    checkOutput("reset.failPulse", 32'(failPulse), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    modelRestart();
  endtask

  logic [W-1:0] goodAns;
  logic [W-1:0] wrongAns;
  int           hold;

  initial begin
    checks    = 0;
    errors    = 0;
    failCount = 0;
    mFails    = 0;
    rst_n     = 1'b1;
    plainIn   = 8'hA5;
    keyIn     = 8'h3C;
    answerIn  = 8'h00;
    submitBtn = 1'b0;
    newRound  = 1'b0;
    modelRestart();
    #2;
    rst_n = 1'b0;

    // Reset then idle.
    doReset(3);
    checkModel("idle");

    // Correct answer with explicit latency from the button edge.
    checkOutput("exp.A5^3C", 32'(modelExp(8'hA5, 8'h3C)), 32'h0000_00CC);
    @(negedge clk);
    answerIn  = 8'hCC;
    submitBtn = 1'b1;
    repeat (DB + 3) @(negedge clk);
    checkOutput("latency.before", 32'(verifier), 32'd0);
    @(negedge clk);
    checkOutput("latency.at", 32'(verifier), 32'd1);
    repeat (4) @(negedge clk);
    submitBtn = 1'b0;
    repeat (10) @(negedge clk);
    mPassed = 1'b1;
    checkModel("pass");
    applyStimulus(8'h00, 10);
    checkModel("pass.second");

    // Glitch shorter than the debounce window, then a long hold.
    pulseNewRound();
    applyStimulus(8'h00, 2);
    checkModel("glitch");
    applyStimulus(8'h00, 20);
    checkModel("longhold");

    // Exhaust attempts, confirm lockout ignores a correct answer, then recover.
    applyStimulus(8'h00, 8);
    checkModel("wrong2");
    applyStimulus(8'h00, 8);
    checkModel("wrong3");
    checkOutput("lock.locked", 32'(locked), 32'd1);
    applyStimulus(8'hCC, 8);
    checkModel("locked.correct");
    pulseNewRound();
    checkModel("recover");
    applyStimulus(8'hCC, 8);
    checkModel("recover.pass");

    // new_round coincident with press discards the press.
    pulseNewRound();
    @(negedge clk);
    answerIn  = 8'hCC;
    submitBtn = 1'b1;
    repeat (DB + 2) @(negedge clk);
    newRound = 1'b1;
    @(negedge clk);
    newRound = 1'b0;
    repeat (6) @(negedge clk);
    submitBtn = 1'b0;
    repeat (6) @(negedge clk);
    modelRestart();
    checkModel("race.newround");
    applyStimulus(8'hCC, 8);
    checkModel("race.after");

    // Asynchronous reset while the wrong answer is being compared.
    pulseNewRound();
    @(negedge clk);
    answerIn  = 8'h00;
    submitBtn = 1'b1;
    repeat (DB + 3) @(negedge clk);
    submitBtn = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncrst.verifier", 32'(verifier), 32'd0);
    checkOutput("asyncrst.locked", 32'(locked), 32'd0);
    checkOutput("asyncrst.attempts", 32'(attemptsLeft), 32'(TRIES));
    checkOutput("asyncrst.failPulse", 32'(failPulse), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    modelRestart();
    checkModel("asyncrst.after");

    // Randomized traffic against the round-level model.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) < 2) begin
        plainIn = W'($urandom);
        keyIn   = W'($urandom);
        pulseNewRound();
        checkModel("rand.newround");
      end else begin
        goodAns  = modelExp(plainIn, keyIn);
        wrongAns = W'($urandom);
        if ($urandom_range(0, 3) == 0) hold = $urandom_range(1, DB - 1);
        else hold = $urandom_range(DB + 2, DB + 10);
        applyStimulus(($urandom_range(0, 1) == 1) ? goodAns : wrongAns, hold);
        checkModel("rand.press");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/level3_answer_checker.md
Name: level3_answer_checker

Overview:
Upstream stage of the level-3 verifier LED driver. It captures the player's switch-entered answer on a debounced submit press and compares it against the level-3 cipher of the round's plaintext and key. It drives the `verifier` level consumed by the LED driver, so green means pass and red means not passed. It also tracks remaining attempts and locks the round out when they are exhausted.

Parameters:
- WIDTH, 8: width of plaintext, key and answer.
- ROT, 3: left-rotate amount of the level-3 cipher; legal range 0..WIDTH-1.
- MAX_TRIES, 3: attempts per round; must be at least 1.
- DB_CYCLES, 4: cycles `submit_btn` must be stable high before it is accepted; must be at least 1.

Ports:
- clk, input, 1: system clock; single clock domain.
- rst_n, input, 1: reset, asynchronous, active-low.
- plain_in, input, WIDTH: round plaintext; stable while the round is active.
- key_in, input, WIDTH: round key; stable while the round is active.
- answer_in, input, WIDTH: player answer from the switches; asynchronous, sampled only at capture.
- submit_btn, input, 1: raw push button, active-high, asynchronous.
- new_round, input, 1: synchronous, one-cycle pulse; restarts the round.
- verifier, output, 1: 1 = correct answer (to the LED driver), 0 otherwise.
- attempts_left, output, $clog2(MAX_TRIES+1): remaining attempts.
- locked, output, 1: 1 when attempts are exhausted.
- fail_pulse, output, 1: one-cycle pulse per wrong answer.

Behaviour:
- Reset values: verifier=0, locked=0, fail_pulse=0, attempts_left=MAX_TRIES, state=IDLE, synchronisers=0, debounce counter=0.
- Input conditioning:
  - `submit_btn` passes through a 2-flop synchroniser.
  - The debounce counter increments while the synchronised level is 1 and saturates at DB_CYCLES. It clears to 0 whenever the synchronised level is 0.
  - `press` is a single-cycle pulse when the counter first reaches DB_CYCLES.
  - A held button yields exactly one `press`. A release and a new stable press are required for the next one.
  - `answer_in` is captured as a raw WIDTH-bit register on `press`; switches are static at that moment.
- Expected value: `exp = rotl(plain_in ^ key_in, ROT)`, combinational, WIDTH bits, no carry. ROT=0 means plain XOR.
- State machine:
  - IDLE: on `press`, capture the answer and go to CHECK.
  - CHECK (exactly one cycle):
    - If `ans_q == exp`, go to PASS.
    - Otherwise decrement `attempts_left`, assert `fail_pulse` for one cycle, and go to FAIL if the new count is greater than 0, else to LOCKED.
  - FAIL: on `press`, capture and go to CHECK.
  - PASS: ignore `press`.
  - LOCKED: ignore `press`.
- Outputs are registered:
  - `verifier`=1 exactly while in PASS.
  - `locked`=1 exactly while in LOCKED.
  - `fail_pulse` is high in the cycle after the CHECK→FAIL/LOCKED edge.
- Latency: the cycle with `press` high is cycle N. The state is CHECK in cycle N+1. `verifier`/`locked`/`attempts_left` update in cycle N+2.
- `new_round` in any state:
  - Go to IDLE, reload `attempts_left`=MAX_TRIES, set verifier=0, locked=0, fail_pulse=0.
  - Debounce and synchroniser state is untouched.
- Simultaneous `new_round` and `press`: `new_round` wins and the press is discarded.
- `new_round` during CHECK: the comparison is discarded and attempts are not decremented.
- `attempts_left` never underflows. It is only decremented from values of at least 1.
- An asynchronous `rst_n` assertion mid-operation returns everything to reset values immediately, with no dependency on clk. Deassertion is used as-is; the board provides a synchronised release.
- Changes to `plain_in`/`key_in` after capture alter `exp`. They must therefore be stable from `press` through CHECK; outside that window they are don't-care.

Decomposition:
- Shared package `game_pkg`:
  - `state_t` enum: IDLE, CHECK, PASS, FAIL, LOCKED.
  - `rotl` function.
  - Default constants LVL3_ROT=3 and LVL3_TRIES=3.
- One natural sub-module, `btn_debounce`: synchroniser, saturating counter and single-pulse output, parameterised by DB_CYCLES. It is reused by the other levels.
- The checker instantiates `btn_debounce` and contains the FSM and compare logic.

Test Plan:
1. Reset then idle: `rst_n` low 3 cycles → verifier=0, locked=0, attempts_left=3, fail_pulse=0.
2. Correct answer: WIDTH=8, plain=8'hA5, key=8'h3C, answer=8'hCC, press held 10 cycles → verifier=1 two cycles after `press`, attempts_left stays 3. A second press → no change.
3. Debounce and glitch: a 2-cycle button glitch with DB_CYCLES=4 → no capture. One 20-cycle hold → exactly one CHECK.
4. Wrong answers to lockout: answer=8'h00 pressed three times →
   - fail_pulse ×3; attempts_left 2, 1, 0.
   - locked=1 after the third; verifier=0.
   - A further press with 8'hCC → still locked.
5. Recovery: from LOCKED, a `new_round` pulse → IDLE, attempts_left=3, locked=0. Then answer 8'hCC → verifier=1.
6. Races:
   - `new_round` coincident with `press` → IDLE, no CHECK.
   - `rst_n` asserted during CHECK → outputs at reset values within the same cycle, no fail_pulse.
